// File: rtl/lu_arb_pkg.sv
// Shared definitions for the flow-table lookup arbiter: state encoding,
// index-width helper and slice offsets for the flattened requester buses.
package lu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } lu_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request bit strictly after last_idx,
// wrapping at NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               valid_c,
    output logic [IDX_W-1:0]   idx_c
);

    int unsigned cand;

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_idx) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid_c && req[IDX_W'(cand)]) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/lu_req_arbiter.sv
// Round-robin arbiter sharing one flow-table lookup port between NUM_REQ
// packet preprocessors, with grant/contention/spurious-ack statistics.
module lu_req_arbiter
    import lu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ               = 5,
    parameter int unsigned OPENFLOW_MATCH_SIZE   = 256,
    parameter int unsigned C_AXIS_LEN_DATA_WIDTH = 16,
    parameter int unsigned DATA_WIDTH            = 32,
    localparam int unsigned IDX_W                = clog2(NUM_REQ)
) (
    input  logic                                       asclk,
    input  logic                                       aresetn,
    input  logic [NUM_REQ-1:0]                         s_lu_req,
    input  logic [NUM_REQ*OPENFLOW_MATCH_SIZE-1:0]     s_lu_entry,
    input  logic [NUM_REQ*C_AXIS_LEN_DATA_WIDTH-1:0]   s_lu_len,
    output logic [NUM_REQ-1:0]                         s_lu_ack,
    output logic                                       m_lu_req,
    output logic [OPENFLOW_MATCH_SIZE-1:0]             m_lu_entry,
    output logic [C_AXIS_LEN_DATA_WIDTH-1:0]           m_lu_len,
    input  logic                                       m_lu_ack,
    output logic [IDX_W-1:0]                           lu_grant_port,
    output logic [DATA_WIDTH-1:0]                      lu_grant_cnt,
    output logic [DATA_WIDTH-1:0]                      lu_contend_cnt,
    output logic [DATA_WIDTH-1:0]                      lu_spur_ack_cnt
);

    logic [OPENFLOW_MATCH_SIZE-1:0]   entry_arr [NUM_REQ];
    logic [C_AXIS_LEN_DATA_WIDTH-1:0] len_arr   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign entry_arr[i] = s_lu_entry[slice_lsb(i, OPENFLOW_MATCH_SIZE) +: OPENFLOW_MATCH_SIZE];
        assign len_arr[i]   = s_lu_len[slice_lsb(i, C_AXIS_LEN_DATA_WIDTH) +: C_AXIS_LEN_DATA_WIDTH];
    end

    lu_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                 grant_port_q, grant_port_d;
    logic [OPENFLOW_MATCH_SIZE-1:0]   entry_q, entry_d;
    logic [C_AXIS_LEN_DATA_WIDTH-1:0] len_q, len_d;
    logic                             m_lu_req_q, m_lu_req_d;
    logic [DATA_WIDTH-1:0]            grant_cnt_q, grant_cnt_d;
    logic [DATA_WIDTH-1:0]            contend_cnt_q, contend_cnt_d;
    logic [DATA_WIDTH-1:0]            spur_cnt_q, spur_cnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (s_lu_req),
        .last_idx (grant_port_q),
        .valid_c  (pick_valid),
        .idx_c    (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_port_d  = grant_port_q;
        entry_d       = entry_q;
        len_d         = len_q;
        grant_cnt_d   = grant_cnt_q;
        contend_cnt_d = contend_cnt_q;
        spur_cnt_d    = spur_cnt_q;
        m_lu_req_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_port_d = pick_idx;
                    entry_d      = entry_arr[pick_idx];
                    len_d        = len_arr[pick_idx];
                    grant_cnt_d  = grant_cnt_q + DATA_WIDTH'(1);
                    state_d      = GRANT;
                end
                if ($countones(s_lu_req) >= 2) begin
                    contend_cnt_d = contend_cnt_q + DATA_WIDTH'(1);
                end
            end
            GRANT: begin
                if (m_lu_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (m_lu_ack && (state_q != GRANT)) begin
            spur_cnt_d = spur_cnt_q + DATA_WIDTH'(1);
        end

        m_lu_req_d = (state_d == GRANT);
    end

    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            grant_port_q  <= IDX_W'(NUM_REQ - 1);
            entry_q       <= '0;
            len_q         <= '0;
            m_lu_req_q    <= 1'b0;
            grant_cnt_q   <= '0;
            contend_cnt_q <= '0;
            spur_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_port_q  <= grant_port_d;
            entry_q       <= entry_d;
            len_q         <= len_d;
            m_lu_req_q    <= m_lu_req_d;
            grant_cnt_q   <= grant_cnt_d;
            contend_cnt_q <= contend_cnt_d;
            spur_cnt_q    <= spur_cnt_d;
        end
    end

    // Ack is steered to the granted requester only; an ack during reset goes nowhere.
    always_comb begin
        s_lu_ack = '0;
        if (aresetn && (state_q == GRANT) && m_lu_ack) begin
            s_lu_ack[grant_port_q] = 1'b1;
        end
    end

    assign m_lu_req        = m_lu_req_q;
    assign m_lu_entry      = entry_q;
    assign m_lu_len        = len_q;
    assign lu_grant_port   = grant_port_q;
    assign lu_grant_cnt    = grant_cnt_q;
    assign lu_contend_cnt  = contend_cnt_q;
    assign lu_spur_ack_cnt = spur_cnt_q;

endmodule

// File: tb/tb_lu_req_arbiter.sv
// Scoreboard bench for lu_req_arbiter: expected grants are queued when requests
// are raised and compared as the arbiter presents each lookup to the table.
module tb_lu_req_arbiter;

    localparam int unsigned NR = 5;
    localparam int unsigned EW = 256;
    localparam int unsigned LW = 16;
    localparam int unsigned DW = 32;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NR-1:0]     s_lu_req;
    logic [NR*EW-1:0]  s_lu_entry;
    logic [NR*LW-1:0]  s_lu_len;
    logic [NR-1:0]     s_lu_ack;
    logic              m_lu_req;
    logic [EW-1:0]     m_lu_entry;
    logic [LW-1:0]     m_lu_len;
    logic              m_lu_ack;
    logic [2:0]        lu_grant_port;
    logic [DW-1:0]     lu_grant_cnt;
    logic [DW-1:0]     lu_contend_cnt;
    logic [DW-1:0]     lu_spur_ack_cnt;

    lu_req_arbiter dut (
        .asclk           (clk),
        .aresetn         (aresetn),
        .s_lu_req        (s_lu_req),
        .s_lu_entry      (s_lu_entry),
        .s_lu_len        (s_lu_len),
        .s_lu_ack        (s_lu_ack),
        .m_lu_req        (m_lu_req),
        .m_lu_entry      (m_lu_entry),
        .m_lu_len        (m_lu_len),
        .m_lu_ack        (m_lu_ack),
        .lu_grant_port   (lu_grant_port),
        .lu_grant_cnt    (lu_grant_cnt),
        .lu_contend_cnt  (lu_contend_cnt),
        .lu_spur_ack_cnt (lu_spur_ack_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [EW-1:0] entry;
        logic [LW-1:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_entry(input int i, input logic [31:0] salt);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ salt ^ 32'(i * 32'h0101_0011);
        return {8{w}};
    endfunction

    function automatic logic [LW-1:0] mk_len(input int i);
        return LW'(64 + 17 * i);
    endfunction

    // One cycle on: drive/sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int i, input logic [EW-1:0] v);
        s_lu_entry[i*EW +: EW] = v;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.idx   = i;
        e.entry = mk_entry(i, 32'h0);
        e.len   = mk_len(i);
        exp_q.push_back(e);
    endtask

    // Act as the flow table: wait for a lookup, check it, ack after lat cycles.
    // The granted requester scrambles its entry while waiting, drops its request
    // after the ack and re-raises it two cycles later when keep is set.
    task automatic serve(input int lat, input bit keep);
        int   n;
        exp_t e;
        n = 0;
        while (!m_lu_req && n < 20) begin
            step();
            n++;
        end
        if (!m_lu_req) begin
            chk("grant_timeout", '0, 1);
            return;
        end
        chk("grant_latency", n, 1);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("grant_port", lu_grant_port, e.idx);
        chk("grant_entry", m_lu_entry, e.entry);
        chk("grant_len", m_lu_len, e.len);
        for (int k = 0; k < lat; k++) begin
            set_entry(e.idx, mk_entry(e.idx, 32'hBAD0_0000 + 32'(k)));
            s_lu_len[e.idx*LW +: LW] = LW'(16'hFFFF - k);
            step();
            chk("entry_hold", m_lu_entry, e.entry);
            chk("req_hold", m_lu_req, 1);
        end
        m_lu_ack = 1'b1;
        #1;
        chk("ack_route", s_lu_ack, NR'(1) << e.idx);
        step();
        m_lu_ack = 1'b0;
        s_lu_req[e.idx] = 1'b0;
        set_entry(e.idx, mk_entry(e.idx, 32'h0));
        s_lu_len[e.idx*LW +: LW] = mk_len(e.idx);
        #1;
        chk("ack_one_cycle", s_lu_ack, 0);
        chk("release_req", m_lu_req, 0);
        step();
        chk("idle_req", m_lu_req, 0);
        if (keep) begin
            s_lu_req[e.idx] = 1'b1;
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        chk("rst_req", m_lu_req, 0);
        chk("rst_entry", m_lu_entry, 0);
        chk("rst_len", m_lu_len, 0);
        chk("rst_ack", s_lu_ack, 0);
        chk("rst_port", lu_grant_port, 4);
        chk("rst_gcnt", lu_grant_cnt, 0);
        chk("rst_ccnt", lu_contend_cnt, 0);
        chk("rst_scnt", lu_spur_ack_cnt, 0);
        aresetn = 1'b1;
    endtask

    initial begin : main
        int lats[6];
        lats = '{4, 1, 2, 3, 1, 2};
        aresetn    = 1'b0;
        s_lu_req   = '0;
        m_lu_ack   = 1'b0;
        s_lu_entry = '0;
        s_lu_len   = '0;
        for (int i = 0; i < NR; i++) begin
            set_entry(i, mk_entry(i, 32'h0));
            s_lu_len[i*LW +: LW] = mk_len(i);
        end
        step();
        do_reset();

        // Single requester, table latency 4.
        s_lu_req = 5'b00001;
        push_exp(0);
        serve(4, 1'b0);
        chk("single_gcnt", lu_grant_cnt, 1);
        chk("single_ccnt", lu_contend_cnt, 0);

        // All five requesting from a fresh reset: rotation 0,1,2,3,4,0.
        do_reset();
        s_lu_req = 5'b11111;
        for (int i = 0; i < 6; i++) push_exp(i % NR);
        for (int i = 0; i < 5; i++) serve(lats[i], 1'b1);
        chk("rr_ccnt5", lu_contend_cnt, 5);
        chk("rr_gcnt5", lu_grant_cnt, 5);
        serve(lats[5], 1'b0);
        s_lu_req = '0;
        chk("rr_gcnt6", lu_grant_cnt, 6);
        chk("rr_ccnt6", lu_contend_cnt, 6);

        // Spurious ack while idle.
        step();
        m_lu_ack = 1'b1;
        #1;
        chk("spur_no_ack", s_lu_ack, 0);
        step();
        m_lu_ack = 1'b0;
        chk("spur_cnt", lu_spur_ack_cnt, 1);
        chk("spur_idle_req", m_lu_req, 0);
        step();
        chk("spur_stay_idle", m_lu_req, 0);
        chk("spur_gcnt", lu_grant_cnt, 6);

        // Reset while requester 3 holds the grant (last grant was 0).
        s_lu_req = 5'b01000;
        step();
        chk("mid_req", m_lu_req, 1);
        chk("mid_port", lu_grant_port, 3);
        aresetn  = 1'b0;
        m_lu_ack = 1'b1;
        #1;
        chk("rst_ack_blocked", s_lu_ack, 0);
        step();
        aresetn  = 1'b1;
        m_lu_ack = 1'b0;
        #1;
        chk("mid_rst_req", m_lu_req, 0);
        chk("mid_rst_gcnt", lu_grant_cnt, 0);
        chk("mid_rst_ack", s_lu_ack, 0);
        chk("mid_rst_scnt", lu_spur_ack_cnt, 0);
        s_lu_req = 5'b01001;
        push_exp(0);
        push_exp(3);
        serve(2, 1'b0);
        serve(1, 1'b0);

        // Wrap: put the pointer at 4, then requests {4,1} grant 1 then 4.
        s_lu_req = 5'b10000;
        push_exp(4);
        serve(1, 1'b0);
        chk("wrap_port", lu_grant_port, 4);
        s_lu_req = 5'b10010;
        push_exp(1);
        push_exp(4);
        serve(3, 1'b0);
        serve(1, 1'b0);
        step();
        chk("final_gcnt", lu_grant_cnt, 5);
        chk("final_ccnt", lu_contend_cnt, 2);
        chk("final_scnt", lu_spur_ack_cnt, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
